mips_trace_buffer: RTL and testbench

//  Consumes CPU debug outputs (pc_debug, instruction_debug, alu_result_debug) downstream of MIPS_CPU.

---
 rtl/mips_trace_buffer.sv | 160 ++++++++++++++++
 tb/tb_mips_trace_buffer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mips_trace_buffer.sv
// Trace capture for MIPS_CPU debug outputs: one FIFO entry per new PC, sticky overflow and halt detect.
// Define TRACE_ALU_EN to carry alu_in through the FIFO and expose trace_alu.
module mips_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int HALT_REPEAT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       capture_en,
  input  logic [31:0]                pc_in,
  input  logic [31:0]                instr_in,
`ifdef TRACE_ALU_EN
  input  logic [31:0]                alu_in,
`endif
  input  logic                       trace_ready,
  output logic                       trace_valid,
  output logic [31:0]                trace_pc,
  output logic [31:0]                trace_instr,
`ifdef TRACE_ALU_EN
  output logic [31:0]                trace_alu,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       halted
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int RW = $clog2(HALT_REPEAT);
`ifdef TRACE_ALU_EN
  localparam int EW = 96;
`else
  localparam int EW = 64;
`endif

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     last_pc_reg, last_pc_next;
  logic [RW-1:0]   repeat_reg, repeat_next;
  logic            push_req;

  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   entry_in;
  logic [EW-1:0]   head_reg, head_next;
  logic [AW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            valid_reg;
  logic            overflow_reg;
  logic            halted_reg;
  logic            full, pop, do_write, drop;

`ifdef TRACE_ALU_EN
  assign entry_in = {pc_in, instr_in, alu_in};
`else
  assign entry_in = {pc_in, instr_in};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      last_pc_reg <= '0;
      repeat_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      last_pc_reg <= last_pc_next;
      repeat_reg  <= repeat_next;
    end
  end

  // A repeat count of HALT_REPEAT-1 means the PC has been seen HALT_REPEAT cycles in a row.
  always_comb begin
    state_next   = state_reg;
    last_pc_next = last_pc_reg;
    repeat_next  = repeat_reg;
    push_req     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (capture_en) begin
          push_req     = 1'b1;
          last_pc_next = pc_in;
          repeat_next  = '0;
          state_next   = RUN;
        end
      end
      RUN: begin
        if (capture_en) begin
          if (pc_in != last_pc_reg) begin
            push_req     = 1'b1;
            last_pc_next = pc_in;
            repeat_next  = '0;
          end else begin
            repeat_next = repeat_reg + 1'b1;
            if (repeat_reg == RW'(HALT_REPEAT-2))
              state_next = HALTED;
          end
        end
      end
      HALTED: ;
      default: state_next = IDLE;
    endcase
  end

  assign full     = (count_reg == CW'(DEPTH));
  assign pop      = valid_reg & trace_ready;
  assign do_write = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    wr_ptr_next = do_write ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg;
    case ({do_write, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    // Forward the incoming entry when it lands in the slot that becomes the head.
    head_next = head_reg;
    if (count_next != '0)
      head_next = (do_write && (rd_ptr_next == wr_ptr_reg)) ? entry_in : mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (do_write)
      mem[wr_ptr_reg] <= entry_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      valid_reg    <= 1'b0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      valid_reg    <= (count_next != '0);
      head_reg     <= head_next;
      overflow_reg <= overflow_reg | drop;
      halted_reg   <= (state_next == HALTED);
    end
  end

  assign trace_valid = valid_reg;
  assign trace_pc    = head_reg[EW-1 -: 32];
  assign trace_instr = head_reg[EW-33 -: 32];
`ifdef TRACE_ALU_EN
  assign trace_alu   = head_reg[31:0];
`endif
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign halted      = halted_reg;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed table-driven bench for mips_trace_buffer (DEPTH=16, HALT_REPEAT=4).
module tb_mips_trace_buffer;

  localparam logic [31:0] IMASK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture_en;
  logic [31:0] pc_in, instr_in, alu_in;
  logic        trace_ready;
  logic        trace_valid;
  logic [31:0] trace_pc, trace_instr;
`ifdef TRACE_ALU_EN
  logic [31:0] trace_alu;
`endif
  logic [4:0]  count;
  logic        overflow, halted;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_trace_buffer #(.DEPTH(16), .HALT_REPEAT(4)) dut (
    .clk(clk),
    .reset(reset),
    .capture_en(capture_en),
    .pc_in(pc_in),
    .instr_in(instr_in),
`ifdef TRACE_ALU_EN
    .alu_in(alu_in),
`endif
    .trace_ready(trace_ready),
    .trace_valid(trace_valid),
    .trace_pc(trace_pc),
    .trace_instr(trace_instr),
`ifdef TRACE_ALU_EN
    .trace_alu(trace_alu),
`endif
    .count(count),
    .overflow(overflow),
    .halted(halted)
  );

  typedef struct {
    logic        cap;
    logic [31:0] pc;
    logic        rdy;
    logic        e_valid;
    int          e_count;
    logic        chk_head;
    logic [31:0] e_pc;
    logic        e_ovf;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else
      $display("ok   %s: 0x%08h", name, act);
  endtask

  task automatic add(input logic c, input logic [31:0] p, input logic r, input logic v,
                     input int n, input logic ch, input logic [31:0] hp,
                     input logic o, input logic h);
    vec_t t;
    t.cap = c; t.pc = p; t.rdy = r; t.e_valid = v; t.e_count = n;
    t.chk_head = ch; t.e_pc = hp; t.e_ovf = o; t.e_halt = h;
    vecs.push_back(t);
  endtask

  task automatic step(input logic c, input logic [31:0] p, input logic [31:0] a, input logic r);
    capture_en  = c;
    pc_in       = p;
    instr_in    = p ^ IMASK;
    alu_in      = a;
    trace_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic v, input int n,
                              input logic o, input logic h);
    check({tag, " valid"}, 32'(trace_valid), 32'(v));
    check({tag, " count"}, 32'(count), 32'(n));
    check({tag, " overflow"}, 32'(overflow), 32'(o));
    check({tag, " halted"}, 32'(halted), 32'(h));
  endtask

  initial begin
    reset = 1'b1; capture_en = 1'b0; pc_in = '0; instr_in = '0; alu_in = '0; trace_ready = 1'b0;
    #2;
    check_status("reset", 1'b0, 0, 1'b0, 1'b0);
    check("reset trace_pc", trace_pc, 32'h0);
    #10 reset = 1'b0;

    // Three pushes with the consumer stalled, then drain them.
    add(1, 32'h0, 0, 1, 1, 1, 32'h0, 0, 0);
    add(1, 32'h4, 0, 1, 2, 1, 32'h0, 0, 0);
    add(1, 32'h8, 0, 1, 3, 1, 32'h0, 0, 0);
    add(0, 32'h8, 1, 1, 2, 1, 32'h4, 0, 0);
    add(0, 32'h8, 1, 1, 1, 1, 32'h8, 0, 0);
    add(0, 32'h8, 1, 0, 0, 0, 32'h0, 0, 0);
    // Seventeen distinct PCs into a 16-deep FIFO: the last one is dropped.
    for (int i = 0; i < 17; i++)
      add(1, 32'h100 + 32'(4*i), 0, 1, (i < 16) ? i + 1 : 16, 1, 32'h100, (i == 16), 0);
    // Push while full with a simultaneous pop.
    add(1, 32'h200, 1, 1, 16, 1, 32'h104, 1, 0);
    for (int k = 1; k <= 16; k++)
      add(0, 32'h200, 1, (k < 16), 16 - k, (k < 16),
          (k < 15) ? 32'h104 + 32'(4*k) : 32'h200, 1, 0);
    // Self-loop at 0x1C: one entry, halt on the fourth edge, nothing pushed afterwards.
    add(1, 32'h1C, 0, 1, 1, 1, 32'h1C, 1, 0);
    add(1, 32'h1C, 0, 1, 1, 1, 32'h1C, 1, 0);
    add(1, 32'h1C, 0, 1, 1, 1, 32'h1C, 1, 0);
    add(1, 32'h1C, 0, 1, 1, 1, 32'h1C, 1, 1);
    add(1, 32'h20, 0, 1, 1, 1, 32'h1C, 1, 1);
    add(1, 32'h24, 0, 1, 1, 1, 32'h1C, 1, 1);
    add(1, 32'h28, 1, 0, 0, 0, 32'h0,  1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d pc=%0h", i, vecs[i].pc);
      step(vecs[i].cap, vecs[i].pc, 32'h0, vecs[i].rdy);
      check_status(tag, vecs[i].e_valid, vecs[i].e_count, vecs[i].e_ovf, vecs[i].e_halt);
      if (vecs[i].chk_head) begin
        check({tag, " trace_pc"}, trace_pc, vecs[i].e_pc);
        check({tag, " trace_instr"}, trace_instr, vecs[i].e_pc ^ IMASK);
      end
    end

    // Mid-cycle reset pulse clears sticky overflow and halted without a clock edge.
    #2 reset = 1'b1;
    #1 check_status("rst1", 1'b0, 0, 1'b0, 1'b0);
    #4 reset = 1'b0;

    // Refill to five entries and halt, then reset mid-cycle again.
    for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(4*i), 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h310, 32'h0, 1'b0);
    check_status("pre-rst2", 1'b1, 5, 1'b0, 1'b1);
    check("pre-rst2 trace_pc", trace_pc, 32'h300);
    #2 reset = 1'b1;
    #1 check_status("rst2", 1'b0, 0, 1'b0, 1'b0);
    check("rst2 trace_pc", trace_pc, 32'h0);
    #3 reset = 1'b0;
    step(1'b0, 32'h0, 32'h0, 1'b1);
    check_status("post-rst2", 1'b0, 0, 1'b0, 1'b0);

`ifdef TRACE_ALU_EN
    step(1'b1, 32'h40, 32'hDEADBEEF, 1'b0);
    check_status("alu", 1'b1, 1, 1'b0, 1'b0);
    check("alu trace_pc", trace_pc, 32'h40);
    check("alu trace_alu", trace_alu, 32'hDEADBEEF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
